dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder at the far end of the memory-stage interface. Serves the MemRW/address/data requests issued by the memory-stage control logic.
- Accepts one load or store per handshake and waits a configurable number of cycles. Performs byte/half/word access with RISC-V funct3 semantics, then returns a one-cycle response (load data or store acknowledge).
- Sits between the pipeline MEM stage and a word-organised on-chip RAM array held inside the block.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two.
- LATENCY, 2, wait cycles between request acceptance and response; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- MemRW  input  1  1 = store, 0 = load.
- funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle response strobe.
- rdata  output  32  load result, extended; 0 for stores and errors.
- resp_err  output  1  request rejected; valid only with resp_valid.

Behaviour:
- Reset: asynchronous, active-high. req_ready=1, resp_valid=0, rdata=0, resp_err=0, state=IDLE, counter=0. RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid=1 at a rising edge, the block captures MemRW, funct3, addr and wdata, loads cnt=LATENCY-1 and moves to WAIT.
- WAIT: req_ready=0. While cnt!=0, the counter decrements each edge. When cnt==0, the next edge moves to RESP and, on that same edge:
  - performs the store (byte-enabled write), or
  - registers the load result into rdata,
  - and sets resp_err.
- RESP: resp_valid=1 for exactly one cycle, then unconditionally IDLE. Outputs rdata and resp_err hold their values until the next RESP update.
- Timing: with acceptance at edge E0, resp_valid is high from edge E0+LATENCY to E0+LATENCY+1. The earliest next acceptance is edge E0+LATENCY+2.
- Inputs are ignored outside IDLE; the captured values are used throughout.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Store byte enables:
  - sb: lane addr[1:0], data wdata[7:0].
  - sh: lanes {addr[1],0} and {addr[1],1}, data wdata[15:0].
  - sw: all four lanes.
- Load extraction:
  - lb/lbu: byte at addr[1:0], sign-extended (lb) or zero-extended (lbu).
  - lh/lhu: half at addr[1], sign-extended (lh) or zero-extended (lhu).
  - lw: full word.
- Illegal funct3: loads 011/110/111; stores any funct3 other than 000/001/010. Result: resp_err=1, no write, rdata=0, full latency still applies.
- Reset asserted mid-operation (WAIT): request aborted, no write performed, outputs return to reset values immediately.
- rdata=0 on every store response.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=00, gives resp_err=1, no write, rdata=0.
- Undefined: offset bits below the access size are ignored.
  - Half accesses use addr[1] only.
  - Word accesses force alignment.
  - resp_err=0 for misalignment.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding ST_IDLE/ST_WAIT/ST_RESP (2 bits);
  - LATENCY_MAX=15;
  - counter width 4.
- Sub-module dmem_lane_align (combinational), used by the FSM top that owns the RAM and the handshake:
  - store side: funct3, addr[1:0], wdata -> byte enables and shifted data, plus illegal/misalign flag;
  - load side: word, funct3, addr[1:0] -> extended rdata.

Test Plan:
- Reset then sw addr=0x10 wdata=0xDEADBEEF, then lw addr=0x10 -> store ack resp_valid at E0+2 with rdata=0; load returns 0xDEADBEEF, resp_err=0.
- After the above, sb addr=0x11 wdata=0x55; then lb addr=0x11 -> 0x00000055; lw 0x10 -> 0xDEAD55EF. Then sb 0x13 0x80; lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080.
- sh addr=0x22 wdata=0x8001; lh 0x22 -> 0xFFFF8001; lhu 0x22 -> 0x00008001; lw 0x20 -> upper half 0x8001.
- LATENCY=4, req_valid held high continuously -> req_ready low for 5 cycles after acceptance; resp_valid exactly one cycle at E0+4; second acceptance at E0+6.
- Load funct3=011, or store funct3=100 -> resp_err=1, rdata=0, memory unchanged (read back). With DMEM_MISALIGN_TRAP_EN: lw addr=0x12 -> resp_err=1. Without it: lw addr=0x12 -> word at 0x10.
- sw 0x30=0x12345678 started, rst pulsed during WAIT -> no resp_valid, req_ready=1 immediately; lw 0x30 returns the prior contents. Address 0x400 with DEPTH_WORDS=256 aliases 0x000.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory responder
package dmem_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wait counter sizing; LATENCY above LATENCY_MAX cannot be represented
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  // Responder control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for funct3 codes a store may use
  function automatic logic f3_store_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // True for funct3 codes a load may use
  function automatic logic f3_load_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage request/response bundle
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        MemRW;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        resp_err;

  // Pipeline MEM stage side
  modport master (
    output req_valid, MemRW, funct3, addr, wdata,
    input  req_ready, resp_valid, rdata, resp_err
  );

  // Responder side
  modport slave (
    input  req_valid, MemRW, funct3, addr, wdata,
    output req_ready, resp_valid, rdata, resp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and load extraction (DMEM_MISALIGN_TRAP_EN enables misalignment errors)
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic       illegal_f3;
  logic       misalign;
  logic [7:0] byte_v;
  logic [15:0] half_v;

  assign illegal_f3 = is_store_i ? !f3_store_legal(funct3_i) : !f3_load_legal(funct3_i);

`ifdef DMEM_MISALIGN_TRAP_EN
  // Halves must sit on even bytes, words on 4-byte boundaries
  assign misalign = (((funct3_i == F3_H) || (funct3_i == F3_HU)) && off_i[0]) ||
                    ((funct3_i == F3_W) && (off_i != 2'b00));
`else
  // Low offset bits below the access size are simply dropped
  assign misalign = 1'b0;
`endif

  assign err_o = illegal_f3 | misalign;

  // Store side: replicate data across lanes, enables select the live ones
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = '0;
      end
    endcase
    if (!is_store_i || err_o) begin
      be_o = 4'b0000;
    end
  end

  assign byte_v = word_i[{off_i, 3'b000} +: 8];
  assign half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

  // Load side: pick the addressed lane and extend; stores and errors read as zero
  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   rdata_o = {24'h0, byte_v};
      F3_H:    rdata_o = {{16{half_v[15]}}, half_v};
      F3_HU:   rdata_o = {16'h0, half_v};
      F3_W:    rdata_o = word_i;
      default: rdata_o = '0;
    endcase
    if (is_store_i || err_o) begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-configurable data-memory responder with internal RAM (DMEM_MISALIGN_TRAP_EN enables misalignment errors)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Out-of-range LATENCY is clamped to what the counter can hold
  localparam int LAT_EFF = (LATENCY < 1) ? 1 : ((LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT_EFF - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              memrw_q, memrw_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [AW-1:0]     word_idx;
  logic [31:0]       rd_word;
  logic              mem_we;

  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;
  logic              acc_err;

  // Address bits above the RAM span alias by design
  logic              unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:AW+2];

  assign word_idx = addr_q[AW+1:2];
  assign rd_word  = mem_q[word_idx];

  dmem_lane_align u_align (
    .is_store_i (memrw_q),
    .funct3_i   (funct3_q),
    .off_i      (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .word_i     (rd_word),
    .be_o       (st_be),
    .wdata_o    (st_data),
    .rdata_o    (ld_data),
    .err_o      (acc_err)
  );

  // Control state, captured request and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      memrw_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      memrw_q  <= memrw_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state: accept in IDLE, count down in WAIT, complete on the exit edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    memrw_d  = memrw_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          memrw_d  = bus.MemRW;
          funct3_d = bus.funct3;
          addr_d   = bus.addr[AW+1:0];
          wdata_d  = bus.wdata;
          cnt_d    = LAT_LOAD;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Lane logic already zeroes enables on loads and errors
          mem_we  = 1'b1;
          rdata_d = ld_data;
          err_d   = acc_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) begin
          mem_q[word_idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.rdata      = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int LAT4  = 4;
  localparam int BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus4 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_n;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mem_m [BYTES];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          req_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: byte-addressed memory, sizes and extension from funct3 rules
  task automatic model(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size;
    bit sgn;
    bit legal;
    int base;
    size = 4; sgn = 0; legal = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !rw; end
      3'd5: begin size = 2; legal = !rw; end
      default: legal = 0;
    endcase
    base = int'(a % BYTES);
    if (base % size != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      legal = 0;
`else
      base = base - (base % size);
`endif
    end
    rd = 32'h0;
    er = !legal;
    if (legal) begin
      if (rw) begin
        for (int i = 0; i < size; i++) mem_m[base + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = mem_m[base + i];
        if (sgn && rd[8*size - 1])
          for (int i = size; i < 4; i++) rd[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  // Monitor: every response strobe must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("rdata#%0d", e.id), bus.rdata, e.rdata);
        check($sformatf("resp_err#%0d", e.id), 32'(bus.resp_err), 32'(e.err));
        check($sformatf("resp_edge#%0d", e.id), 32'(cyc), 32'(e.edge_n));
      end
    end
  end

  // Driver: issue one request at a negedge, push its expectation, drop valid
  task automatic do_req(input logic rw, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int t;
    t = 0;
    while (bus.req_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.req_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, t);
      return;
    end
    bus.req_valid = 1'b1;
    bus.MemRW     = rw;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    model(rw, f3, a, wd, e.rdata, e.err);
    e.edge_n = cyc + 1 + LAT;
    e.id     = req_id;
    req_id++;
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.MemRW     = 1'($urandom);
    bus.funct3    = 3'($urandom);
    bus.addr      = $urandom;
    bus.wdata     = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || bus.req_ready !== 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bus.req_valid = 0; bus.MemRW = 0; bus.funct3 = 0; bus.addr = 0; bus.wdata = 0;
    bus4.req_valid = 0; bus4.MemRW = 0; bus4.funct3 = 0; bus4.addr = 0; bus4.wdata = 0;
    rst = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=4 with req_valid held high
    @(negedge clk);
    bus4.req_valid = 1'b1;
    bus4.MemRW     = 1'b0;
    bus4.funct3    = F3_W;
    bus4.addr      = 32'h0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("lat4_req_ready_k%0d", k), 32'(bus4.req_ready), 32'(k == 5));
      check($sformatf("lat4_resp_valid_k%0d", k), 32'(bus4.resp_valid), 32'(k == 4));
    end
    bus4.req_valid = 1'b0;

    // Give every word a known value
    for (int w = 0; w < DEPTH; w++) do_req(1'b1, F3_W, 32'(w * 4), $urandom);

    // Directed sequences
    do_req(1, F3_W, 32'h10, 32'hDEADBEEF);
    do_req(0, F3_W, 32'h10, 32'h0);
    do_req(1, F3_B, 32'h11, 32'h55);
    do_req(0, F3_B, 32'h11, 32'h0);
    do_req(0, F3_W, 32'h10, 32'h0);
    do_req(1, F3_B, 32'h13, 32'h80);
    do_req(0, F3_B, 32'h13, 32'h0);
    do_req(0, F3_BU, 32'h13, 32'h0);
    do_req(1, F3_H, 32'h22, 32'h8001);
    do_req(0, F3_H, 32'h22, 32'h0);
    do_req(0, F3_HU, 32'h22, 32'h0);
    do_req(0, F3_W, 32'h20, 32'h0);
    do_req(0, 3'b011, 32'h10, 32'h0);
    do_req(1, 3'b100, 32'h10, 32'hFFFFFFFF);
    do_req(1, 3'b111, 32'h10, 32'hFFFFFFFF);
    do_req(0, F3_W, 32'h10, 32'h0);
    do_req(0, F3_W, 32'h12, 32'h0);
    do_req(1, F3_H, 32'h21, 32'h1234);
    do_req(0, F3_W, 32'h20, 32'h0);
    do_req(1, F3_W, 32'h400, 32'hA5A50001);
    do_req(0, F3_W, 32'h000, 32'h0);
    do_req(0, F3_W, 32'h30, 32'h0);

    // Reset during WAIT aborts the store
    drain();
    bus.req_valid = 1'b1;
    bus.MemRW     = 1'b1;
    bus.funct3    = F3_W;
    bus.addr      = 32'h30;
    bus.wdata     = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_rdata", bus.rdata, 32'h0);
    check("abort_resp_err", 32'(bus.resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(0, F3_W, 32'h30, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B;
          1: f3 = F3_H;
          2: f3 = F3_W;
          3: f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end else begin
        f3 = 3'($urandom);
      end
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFFC00);
      do_req(1'($urandom), f3, a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
